// File: rtl/scs8hd_pipe_pkg.sv
// rtl/scs8hd_pipe_pkg.sv - tree-shape helpers for the pipelined and-nb reduction
package scs8hd_pipe_pkg;

  // Number of RADIX-ary tree levels needed to reduce width inputs to one, minimum 1.
  function automatic int clog_radix(input int width, input int radix);
    int levels;
    int span;
    levels = 0;
    span   = 1;
    if (radix < 2) return 1;
    while (span < width) begin
      span   = span * radix;
      levels = levels + 1;
    end
    return (levels < 1) ? 1 : levels;
  endfunction

  // Pipeline stages needed when each stage holds at most lps tree levels.
  function automatic int num_stages(input int levels, input int lps);
    if (lps < 1) return levels;
    return (levels + lps - 1) / lps;
  endfunction

  // Node count remaining after reducing width signals through the given number of levels.
  function automatic int level_width(input int width, input int radix, input int levels);
    int w;
    w = width;
    for (int k = 0; k < levels; k++) begin
      w = (w + radix - 1) / radix;
    end
    return w;
  endfunction

  // Tree levels placed in stage s; only the last stage can be short.
  function automatic int stage_levels(input int total, input int lps, input int s);
    int rem;
    rem = total - s * lps;
    return (rem < lps) ? rem : lps;
  endfunction

endpackage

// File: rtl/scs8hd_andnb_stage.sv
// rtl/scs8hd_andnb_stage.sv - LEVELS of RADIX-ary AND nodes followed by a CE-gated register
module scs8hd_andnb_stage
  import scs8hd_pipe_pkg::*;
#(
  parameter int IN_W    = 4,
  parameter int RADIX   = 4,
  parameter int LEVELS  = 1,
  parameter bit INV_OUT = 1'b0,
  localparam int OUT_W  = level_width(IN_W, RADIX, LEVELS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [IN_W-1:0]  d,
  output logic [OUT_W-1:0] q
);

  // Each level ANDs groups of RADIX neighbours; missing group members read as 1,
  // so a partially filled node behaves exactly like a narrower AND.
  function automatic logic [OUT_W-1:0] reduce_tree(input logic [IN_W-1:0] leaves);
    logic [IN_W-1:0] cur;
    logic [IN_W-1:0] nxt;
    int              w;
    cur = leaves;
    w   = IN_W;
    for (int k = 0; k < LEVELS; k++) begin
      nxt = '1;
      for (int n = 0; n < IN_W; n++) begin
        if (n < w) nxt[n / RADIX] = nxt[n / RADIX] & cur[n];
      end
      cur = nxt;
      w   = (w + RADIX - 1) / RADIX;
    end
    return cur[OUT_W-1:0];
  endfunction

  // Capture the reduced word on every enabled edge; reset leaves a known 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (ce) begin
      q <= reduce_tree(d) ^ {OUT_W{INV_OUT}};
    end
  end

endmodule

// File: rtl/scs8hd_andnb_pipe.sv
// rtl/scs8hd_andnb_pipe.sv - pipelined WIDTH-input AND with per-input inversion and valid tracking
module scs8hd_andnb_pipe
  import scs8hd_pipe_pkg::*;
#(
  parameter int               WIDTH            = 16,
  parameter logic [WIDTH-1:0] INV_MASK         = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               RADIX            = 4,
  parameter int               LEVELS_PER_STAGE = 1,
  parameter bit               OUT_INV          = 1'b0
) (
`ifdef SC_USE_PG_PIN
  input  logic             vpwr,
  input  logic             vgnd,
  input  logic             vpb,
  input  logic             vnb,
`endif
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             CE,
  input  logic             CLR,
  input  logic             VALID_IN,
  input  logic [WIDTH-1:0] A,
  output logic             X,
  output logic             VALID_OUT
);

`ifndef SC_USE_PG_PIN
  supply1 vpwr;
  supply0 vgnd;
  supply1 vpb;
  supply0 vnb;
`endif

  localparam int L = clog_radix(WIDTH, RADIX);
  localparam int S = num_stages(L, LEVELS_PER_STAGE);

  if (WIDTH < 2) begin : g_bad_width
    $error("scs8hd_andnb_pipe: WIDTH must be at least 2");
  end
  if (RADIX < 2 || RADIX > 4) begin : g_bad_radix
    $error("scs8hd_andnb_pipe: RADIX must be 2..4");
  end
  if (LEVELS_PER_STAGE < 1) begin : g_bad_lps
    $error("scs8hd_andnb_pipe: LEVELS_PER_STAGE must be at least 1");
  end

  // Holding the cell in reset while its supplies are not good keeps X deterministic.
  logic pwr_good;
  logic rst_n;
  assign pwr_good = vpwr & vpb & ~vgnd & ~vnb;
  assign rst_n    = RESETB & pwr_good;

  logic [WIDTH-1:0] masked;
  assign masked = A ^ INV_MASK;

  for (genvar s = 0; s < S; s++) begin : g_stage
    localparam int IW = level_width(WIDTH, RADIX, s * LEVELS_PER_STAGE);
    localparam int LV = stage_levels(L, LEVELS_PER_STAGE, s);
    localparam int OW = level_width(IW, RADIX, LV);
    logic [IW-1:0] d;
    logic [OW-1:0] q;
    if (s == 0) begin : g_first
      assign d = masked;
    end else begin : g_next
      assign d = g_stage[s-1].q;
    end
    scs8hd_andnb_stage #(
      .IN_W    (IW),
      .RADIX   (RADIX),
      .LEVELS  (LV),
      .INV_OUT ((s == S - 1) ? OUT_INV : 1'b0)
    ) u_stage (
      .clk   (CLK),
      .rst_n (rst_n),
      .ce    (CE),
      .d     (d),
      .q     (q)
    );
  end

  assign X = g_stage[S-1].q[0];

  // Valid bits shadow the data stages; CLR empties them even while CE holds the data.
  logic [S-1:0] vld;
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (CLR) begin
      vld <= '0;
    end else if (CE) begin
      vld[0] <= VALID_IN;
      for (int i = 1; i < S; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  assign VALID_OUT = vld[S-1];

`ifndef functional
  reg notifier;
  specify
    (CLK => X) = (0:0:0, 0:0:0);
    (CLK => VALID_OUT) = (0:0:0, 0:0:0);
    $setuphold(posedge CLK, A, 0:0:0, 0:0:0, notifier);
    $setuphold(posedge CLK, CE, 0:0:0, 0:0:0, notifier);
    $setuphold(posedge CLK, CLR, 0:0:0, 0:0:0, notifier);
    $setuphold(posedge CLK, VALID_IN, 0:0:0, 0:0:0, notifier);
  endspecify
`endif

endmodule
